// File: rtl/cook_timer.sv
`default_nettype none
// ============================================================================
// Module      : cook_timer
// Description : Four-digit BCD MM:SS countdown feeding the magnetron
//               controller. Optional +30 s key when COOK_ADD30_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module cook_timer #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       clear,
    input  logic       enable,
`ifdef COOK_ADD30_EN
    input  logic       add30,
`endif
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       timer_done
);

    localparam int c_presc_w = $clog2(TICK_DIV);
    localparam logic [c_presc_w-1:0] c_tick_last = c_presc_w'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SET  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [3:0]             r_mt, r_mo, r_st, r_so;
    logic [3:0]             w_mt_nxt, w_mo_nxt, w_st_nxt, w_so_nxt;
    logic [c_presc_w-1:0]   r_presc, w_presc_nxt;
    logic                   r_running, r_done;
    logic                   w_time_nz;
    logic                   w_digit_acc;

    assign w_time_nz   = |{r_mt, r_mo, r_st, r_so};
    assign w_digit_acc = digit_valid && (r_state != S_RUN) && (digit <= 4'd9);

`ifdef COOK_ADD30_EN
    // Total seconds plus 30, saturated at 99:59 and split back into BCD digits.
    logic [12:0] w_t, w_ts;
    logic [6:0]  w_min, w_sec;
    logic [3:0]  w_add_mt, w_add_mo, w_add_st, w_add_so;

    always_comb begin
        if (r_state == S_DONE) begin
            w_t = 13'd30;
        end else begin
            w_t = 13'(r_mt) * 13'd600 + 13'(r_mo) * 13'd60
                + 13'(r_st) * 13'd10 + 13'(r_so) + 13'd30;
        end
        w_ts     = (w_t > 13'd5999) ? 13'd5999 : w_t;
        w_min    = 7'(w_ts / 13'd60);
        w_sec    = 7'(w_ts % 13'd60);
        w_add_mt = 4'(w_min / 7'd10);
        w_add_mo = 4'(w_min % 7'd10);
        w_add_st = 4'(w_sec / 7'd10);
        w_add_so = 4'(w_sec % 7'd10);
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_mt_nxt    = r_mt;
        w_mo_nxt    = r_mo;
        w_st_nxt    = r_st;
        w_so_nxt    = r_so;
        w_presc_nxt = '0;
        if (clear) begin
            w_mt_nxt    = 4'd0;
            w_mo_nxt    = 4'd0;
            w_st_nxt    = 4'd0;
            w_so_nxt    = 4'd0;
            w_state_nxt = S_IDLE;
        end else if (w_digit_acc) begin
            // An entry after DONE starts from a blank display.
            if (r_state == S_DONE) begin
                w_mt_nxt = 4'd0;
                w_mo_nxt = 4'd0;
                w_st_nxt = 4'd0;
            end else begin
                w_mt_nxt = r_mo;
                w_mo_nxt = r_st;
                w_st_nxt = r_so;
            end
            w_so_nxt    = digit;
            w_state_nxt = (|{w_mt_nxt, w_mo_nxt, w_st_nxt, w_so_nxt}) ? S_SET : S_IDLE;
`ifdef COOK_ADD30_EN
        end else if (add30) begin
            w_mt_nxt = w_add_mt;
            w_mo_nxt = w_add_mo;
            w_st_nxt = w_add_st;
            w_so_nxt = w_add_so;
            if (r_state == S_RUN && enable) begin
                w_state_nxt = S_RUN;
                w_presc_nxt = r_presc;
            end else begin
                w_state_nxt = S_SET;
            end
`endif
        end else begin
            case (r_state)
                S_IDLE, S_SET: begin
                    if (enable && w_time_nz) w_state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (!enable) begin
                        w_state_nxt = S_SET;
                    end else if (r_presc == c_tick_last) begin
                        if (r_so != 4'd0) begin
                            w_so_nxt = r_so - 4'd1;
                            if ({r_mt, r_mo, r_st} == 12'd0 && r_so == 4'd1)
                                w_state_nxt = S_DONE;
                        end else if (r_st != 4'd0) begin
                            w_st_nxt = r_st - 4'd1;
                            w_so_nxt = 4'd9;
                        end else if (r_mo != 4'd0) begin
                            w_mo_nxt = r_mo - 4'd1;
                            w_st_nxt = 4'd5;
                            w_so_nxt = 4'd9;
                        end else begin
                            w_mt_nxt = r_mt - 4'd1;
                            w_mo_nxt = 4'd9;
                            w_st_nxt = 4'd5;
                            w_so_nxt = 4'd9;
                        end
                    end else begin
                        w_presc_nxt = r_presc + 1'b1;
                    end
                end
                S_DONE: ;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_mt      <= 4'd0;
            r_mo      <= 4'd0;
            r_st      <= 4'd0;
            r_so      <= 4'd0;
            r_presc   <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_mt      <= w_mt_nxt;
            r_mo      <= w_mo_nxt;
            r_st      <= w_st_nxt;
            r_so      <= w_so_nxt;
            r_presc   <= w_presc_nxt;
            r_running <= (w_state_nxt == S_RUN);
            r_done    <= (w_state_nxt == S_DONE);
        end
    end

    assign min_tens   = r_mt;
    assign min_ones   = r_mo;
    assign sec_tens   = r_st;
    assign sec_ones   = r_so;
    assign running    = r_running;
    assign timer_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cook_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cook_timer
// Description : Self-checking bench for cook_timer with TICK_DIV = 4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cook_timer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       digit_valid = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       clear = 1'b0;
    logic       enable = 1'b0;
    logic       add30 = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, timer_done;

    int n_chk  = 0;
    int n_fail = 0;

    cook_timer #(.TICK_DIV(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .digit_valid (digit_valid),
        .digit       (digit),
        .clear       (clear),
        .enable      (enable),
`ifdef COOK_ADD30_EN
        .add30       (add30),
`endif
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .running     (running),
        .timer_done  (timer_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic        dv;
        logic [3:0]  dg;
        logic        en;
        logic [15:0] exp_t;
        logic        exp_run;
        logic        exp_done;
    } vec_t;

    vec_t tbl [20];

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] et, input logic er, input logic ed);
        logic [15:0] got;
        got = {min_tens, min_ones, sec_tens, sec_ones};
        n_chk++;
        if (got !== et || running !== er || timer_done !== ed) begin
            n_fail++;
            $display("FAIL %s: got %h run=%b done=%b, expected %h run=%b done=%b",
                     nm, got, running, timer_done, et, er, ed);
        end
    endtask

    task automatic key(input logic [3:0] d);
        digit_valid = 1'b1;
        digit       = d;
        adv(1);
        digit_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        adv(1);
        clear = 1'b0;
    endtask

    task automatic pulse_add30();
        add30 = 1'b1;
        adv(1);
        add30 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            clr   dv    dg     en    time      run   done
        tbl[0]  = '{1'b0, 1'b1, 4'd1,  1'b0, 16'h0001, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 4'd3,  1'b0, 16'h0013, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 4'd0,  1'b0, 16'h0130, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 4'hA,  1'b0, 16'h0130, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 4'd2,  1'b0, 16'h1302, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 4'd0,  1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 4'd0,  1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 4'd5,  1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 4'd1,  1'b0, 16'h0001, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 4'd2,  1'b0, 16'h0012, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 4'd3,  1'b0, 16'h0123, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 4'd4,  1'b0, 16'h1234, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 4'd5,  1'b0, 16'h2345, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 4'd9,  1'b0, 16'h3459, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 4'd0,  1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 4'd0,  1'b1, 16'h0000, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 4'd7,  1'b1, 16'h0007, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 4'd0,  1'b1, 16'h0007, 1'b1, 1'b0};
        tbl[18] = '{1'b0, 1'b1, 4'd3,  1'b1, 16'h0007, 1'b1, 1'b0};
        tbl[19] = '{1'b1, 1'b0, 4'd0,  1'b1, 16'h0000, 1'b0, 1'b0};

        adv(2);
        chk("reset_state", 16'h0000, 1'b0, 1'b0);
        rst_n = 1'b1;
        adv(1);
        chk("post_reset_idle", 16'h0000, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            clear       = tbl[i].clr;
            digit_valid = tbl[i].dv;
            digit       = tbl[i].dg;
            enable      = tbl[i].en;
            adv(1);
            chk($sformatf("vec%0d", i), tbl[i].exp_t, tbl[i].exp_run, tbl[i].exp_done);
        end
        clear = 1'b0; digit_valid = 1'b0; enable = 1'b0;
        adv(1);

        // First tick lands TICK_DIV cycles after the SET->RUN edge.
        key(1); key(3); key(0);
        chk("load_0130", 16'h0130, 1'b0, 1'b0);
        enable = 1'b1;
        adv(4);
        chk("run_before_tick", 16'h0130, 1'b1, 1'b0);
        adv(1);
        chk("tick1_0129", 16'h0129, 1'b1, 1'b0);
        adv(4);
        chk("tick2_0128", 16'h0128, 1'b1, 1'b0);

        // Enable drops on the tick cycle: no decrement, prescaler restarts.
        adv(3);
        enable = 1'b0;
        adv(1);
        chk("pause_on_tick", 16'h0128, 1'b0, 1'b0);
        enable = 1'b1;
        adv(4);
        chk("resume_no_tick", 16'h0128, 1'b1, 1'b0);
        adv(1);
        chk("resume_tick", 16'h0127, 1'b1, 1'b0);

        // Countdown into DONE and its exit via keypad.
        enable = 1'b0;
        pulse_clear();
        key(2);
        enable = 1'b1;
        adv(5);
        chk("run_0001", 16'h0001, 1'b1, 1'b0);
        adv(4);
        chk("reach_done", 16'h0000, 1'b0, 1'b1);
        adv(20);
        chk("done_hold", 16'h0000, 1'b0, 1'b1);
        key(5);
        chk("done_digit", 16'h0005, 1'b0, 1'b0);
        adv(1);
        chk("restart_run", 16'h0005, 1'b1, 1'b0);
        key(3);
        chk("digit_in_run", 16'h0005, 1'b1, 1'b0);

        // Unnormalised seconds count straight down through the minute boundary.
        enable = 1'b0;
        adv(1);
        pulse_clear();
        key(0); key(1); key(9); key(0);
        chk("load_0190", 16'h0190, 1'b0, 1'b0);
        enable = 1'b1;
        adv(1 + 90 * 4);
        chk("run_0100", 16'h0100, 1'b1, 1'b0);
        adv(4);
        chk("run_0059", 16'h0059, 1'b1, 1'b0);
        enable = 1'b0;
        adv(1);
        key(1); key(2); key(3); key(4); key(5);
        chk("five_digits", 16'h2345, 1'b0, 1'b0);

        // Asynchronous reset mid-run.
        pulse_clear();
        key(5);
        enable = 1'b1;
        adv(3);
        chk("pre_reset_run", 16'h0005, 1'b1, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 16'h0000, 1'b0, 1'b0);
        enable = 1'b0;
        adv(2);
        rst_n = 1'b1;
        adv(1);
        chk("after_async_reset", 16'h0000, 1'b0, 1'b0);

`ifdef COOK_ADD30_EN
        key(4); key(5);
        pulse_add30();
        chk("add30_0045", 16'h0115, 1'b0, 1'b0);
        pulse_clear();
        key(9); key(9); key(5); key(0);
        pulse_add30();
        chk("add30_saturate", 16'h9959, 1'b0, 1'b0);
        pulse_clear();
        key(1);
        enable = 1'b1;
        adv(5);
        chk("add30_pre_done", 16'h0000, 1'b0, 1'b1);
        pulse_add30();
        chk("add30_in_done", 16'h0030, 1'b0, 1'b0);
        adv(1);
        chk("add30_to_run", 16'h0030, 1'b1, 1'b0);
        pulse_add30();
        chk("add30_in_run", 16'h0100, 1'b1, 1'b0);
        enable = 1'b0;
        adv(1);
        pulse_clear();
        digit_valid = 1'b1; digit = 4'd7; add30 = 1'b1;
        adv(1);
        digit_valid = 1'b0; add30 = 1'b0;
        chk("digit_beats_add30", 16'h0007, 1'b0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
